// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: result-select encoding,
// load funct3 codes and FSM states.
package wb_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: extracts and sign/zero-extends the byte or
// half selected by the low address bits from a raw memory word.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted_b;
    logic [DATA_WIDTH-1:0] shifted_h;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;

    // Halves ignore addr_lo[0]; misaligned halves never reach this stage.
    always_comb begin
        shifted_b = rdata_i >> {addr_lo_i, 3'b000};
        shifted_h = rdata_i >> {addr_lo_i[1], 4'b0000};
        byte_v    = shifted_b[7:0];
        half_v    = shifted_h[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            F3_LH:   data_o = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires MEM->WB entries into the register-file write port,
// waiting (with timeout) for load data. Optional macro WB_INSTRET_EN builds the
// 64-bit retired-instruction counter; otherwise instret_o is tied to 0.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_W,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_i,
    input  logic [1:0]                in_wb_sel_i,
    input  logic [DATA_WIDTH-1:0]     in_alu_result_i,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus4_i,
    input  logic [2:0]                in_funct3_i,
    input  logic [1:0]                in_addr_lo_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      WB_RegWrite_o,
    output logic [REG_ADDR_WIDTH-1:0] WB_wr_addr_o,
    output logic [DATA_WIDTH-1:0]     WB_wr_data_o,
    output logic                      retire_o,
    output logic                      err_o,
    output logic [63:0]               instret_o
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      lat_rw_q, lat_rw_d;
    logic [REG_ADDR_WIDTH-1:0] lat_rd_q, lat_rd_d;
    logic [2:0]                lat_f3_q, lat_f3_d;
    logic [1:0]                lat_alo_q, lat_alo_d;
    logic                      err_q, err_d;
    logic                      ready_q;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      retire_q, retire_d;

    logic                      accept;
    logic                      in_wait;
    logic                      do_wb;
    logic                      sel_rw;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [2:0]                al_f3;
    logic [1:0]                al_alo;
    logic [DATA_WIDTH-1:0]     aligned;
    logic [DATA_WIDTH-1:0]     wb_data;

    assign accept  = in_valid_i && ready_q;
    assign in_wait = (state_q == WAIT_RSP);
    assign al_f3   = in_wait ? lat_f3_q  : in_funct3_i;
    assign al_alo  = in_wait ? lat_alo_q : in_addr_lo_i;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata_i   (dmem_rdata_i),
        .funct3_i  (al_f3),
        .addr_lo_i (al_alo),
        .data_o    (aligned)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, timeout counter, latched load context, sticky error
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_rw_d  = lat_rw_q;
        lat_rd_d  = lat_rd_q;
        lat_f3_d  = lat_f3_q;
        lat_alo_d = lat_alo_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept && (wb_sel_e'(in_wb_sel_i) == WB_MEM) && !dmem_rvalid_i) begin
                    state_d   = WAIT_RSP;
                    cnt_d     = '0;
                    lat_rw_d  = in_reg_write_i;
                    lat_rd_d  = in_rd_i;
                    lat_f3_d  = in_funct3_i;
                    lat_alo_d = in_addr_lo_i;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-back selection; a response in WAIT_RSP uses the latched context
    always_comb begin
        do_wb   = 1'b0;
        sel_rw  = in_reg_write_i;
        sel_rd  = in_rd_i;
        wb_data = in_alu_result_i;
        if (in_wait) begin
            do_wb   = dmem_rvalid_i;
            sel_rw  = lat_rw_q;
            sel_rd  = lat_rd_q;
            wb_data = aligned;
        end else begin
            case (wb_sel_e'(in_wb_sel_i))
                WB_MEM: begin
                    do_wb   = accept && dmem_rvalid_i;
                    wb_data = aligned;
                end
                WB_PC4: begin
                    do_wb   = accept;
                    wb_data = in_pc_plus4_i;
                end
                default: begin
                    do_wb   = accept;
                    wb_data = in_alu_result_i;
                end
            endcase
        end
        retire_d = do_wb;
        we_d     = do_wb && sel_rw && (sel_rd != '0);
        addr_d   = we_d ? sel_rd  : addr_q;
        data_d   = we_d ? wb_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            lat_rw_q  <= 1'b0;
            lat_rd_q  <= '0;
            lat_f3_q  <= '0;
            lat_alo_q <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            retire_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lat_rw_q  <= lat_rw_d;
            lat_rd_q  <= lat_rd_d;
            lat_f3_q  <= lat_f3_d;
            lat_alo_q <= lat_alo_d;
            err_q     <= err_d;
            ready_q   <= (state_d == IDLE);
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            retire_q  <= retire_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire_d) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

    assign in_ready_o    = ready_q;
    assign WB_RegWrite_o = we_q;
    assign WB_wr_addr_o  = addr_q;
    assign WB_wr_data_o  = data_q;
    assign retire_o      = retire_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: directed scenarios followed by
// random traffic, checked against a behavioural write-back model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_reg_write_i;
    logic [4:0]  in_rd_i;
    logic [1:0]  in_wb_sel_i;
    logic [31:0] in_alu_result_i;
    logic [31:0] in_pc_plus4_i;
    logic [2:0]  in_funct3_i;
    logic [1:0]  in_addr_lo_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        WB_RegWrite_o;
    logic [4:0]  WB_wr_addr_o;
    logic [31:0] WB_wr_data_o;
    logic        retire_o;
    logic        err_o;
    logic [63:0] instret_o;

    always #5 clk = ~clk;

    wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_reg_write_i  (in_reg_write_i),
        .in_rd_i         (in_rd_i),
        .in_wb_sel_i     (in_wb_sel_i),
        .in_alu_result_i (in_alu_result_i),
        .in_pc_plus4_i   (in_pc_plus4_i),
        .in_funct3_i     (in_funct3_i),
        .in_addr_lo_i    (in_addr_lo_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .WB_RegWrite_o   (WB_RegWrite_o),
        .WB_wr_addr_o    (WB_wr_addr_o),
        .WB_wr_data_o    (WB_wr_data_o),
        .retire_o        (retire_o),
        .err_o           (err_o),
        .instret_o       (instret_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passed = 0;
    logic        exp_err = 1'b0;
    longint unsigned ret_cnt = 0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Load result from the architectural rules: pick byte/half, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] alo);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * alo)) & 32'hFF;
        h = (w >> (16 * alo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Monitor: every retire pops one expected write-back.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ret_cnt   = 0;
            last_addr = '0;
            last_data = '0;
        end else begin
            if (WB_RegWrite_o && !retire_o) chk("write_without_retire", 64'd1, 64'd0);
            if (retire_o) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    ret_cnt++;
                    chk("wb_we", 64'(WB_RegWrite_o), 64'(e.we));
                    if (e.we) begin
                        last_addr = e.addr;
                        last_data = e.data;
                    end
                    chk("wb_addr", 64'(WB_wr_addr_o), 64'(last_addr));
                    chk("wb_data", 64'(WB_wr_data_o), 64'(last_data));
                    chk("err_at_retire", 64'(err_o), 64'(exp_err));
`ifdef WB_INSTRET_EN
                    chk("instret", instret_o, 64'(ret_cnt));
`else
                    chk("instret", instret_o, 64'd0);
`endif
                end
            end
        end
    end

    // Issue one entry; dly = cycles until the load response (>TO means never).
    task automatic issue(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] rdata, input int dly);
        exp_t e;
        bit   resp;
        int   last;
        in_valid_i      = 1'b1;
        in_wb_sel_i     = sel;
        in_reg_write_i  = rw;
        in_rd_i         = rd;
        in_alu_result_i = alu;
        in_pc_plus4_i   = pc4;
        in_funct3_i     = f3;
        in_addr_lo_i    = alo;
        resp   = (sel != WB_MEM) || (dly <= TO);
        e.we   = rw && (rd != 5'd0);
        e.addr = rd;
        e.data = (sel == WB_MEM) ? ref_load(rdata, f3, alo) : ((sel == WB_PC4) ? pc4 : alu);
        if (resp) sbq.push_back(e);
        if (sel == WB_MEM && dly == 0) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
        end else begin
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
        end
        @(posedge clk); #1;
        in_valid_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        in_rd_i        = 5'($urandom);
        in_funct3_i    = 3'($urandom);
        in_addr_lo_i   = 2'($urandom);
        in_reg_write_i = 1'($urandom);
        if (sel == WB_MEM && dly > 0) begin
            last = (dly <= TO) ? dly : TO;
            for (int k = 1; k <= last; k++) begin
                chk("ready_low_in_wait", 64'(in_ready_o), 64'd0);
                if (k == dly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rdata;
                end else begin
                    dmem_rdata_i  = $urandom;
                end
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0;
            end
        end
        if (resp) begin
            chk("retire_latency", 64'(retire_o), 64'd1);
        end else begin
            exp_err = 1'b1;
            chk("timeout_err", 64'(err_o), 64'd1);
            chk("timeout_no_retire", 64'(retire_o), 64'd0);
        end
        chk("ready_after", 64'(in_ready_o), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid_i    = 1'b0;
            dmem_rvalid_i = 1'($urandom);
            dmem_rdata_i  = $urandom;
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        int r;
        int dly;
        logic [1:0] sel;
        rst_n = 1'b0;
        in_valid_i = 1'b0; in_reg_write_i = 1'b0; in_rd_i = '0; in_wb_sel_i = '0;
        in_alu_result_i = '0; in_pc_plus4_i = '0; in_funct3_i = '0; in_addr_lo_i = '0;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_we", 64'(WB_RegWrite_o), 64'd0);
        chk("rst_addr", 64'(WB_wr_addr_o), 64'd0);
        chk("rst_data", 64'(WB_wr_data_o), 64'd0);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(WB_ALU, 1'b1, 5'd5, 32'h1234_5678, $urandom, 3'd0, 2'd0, 32'd0, 0);
        idle_cycles(1);
        issue(WB_MEM, 1'b1, 5'd3, $urandom, $urandom, F3_LB, 2'b11, 32'h80FF_FF01, 0);
        issue(WB_MEM, 1'b1, 5'd7, $urandom, $urandom, F3_LHU, 2'b10, 32'hBEEF_0000, 5);
        issue(WB_PC4, 1'b1, 5'd0, $urandom, 32'h0000_0100, 3'd0, 2'd0, 32'd0, 0);
        idle_cycles(2);
        chk("err_before_timeout", 64'(err_o), 64'd0);
        issue(WB_MEM, 1'b1, 5'd9, $urandom, $urandom, F3_LW, 2'd0, $urandom, TO + 1);
        issue(WB_ALU, 1'b1, 5'd4, 32'hCAFE_F00D, $urandom, 3'd0, 2'd0, 32'd0, 0);
        issue(WB_MEM, 1'b1, 5'd10, $urandom, $urandom, F3_LH, 2'b01, 32'h1234_8765, TO);
        chk("err_sticky", 64'(err_o), 64'd1);

        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 2);
            sel = (r == 0) ? WB_ALU : ((r == 1) ? WB_MEM : WB_PC4);
            r   = $urandom_range(0, 19);
            dly = (r < 10) ? 0 : ((r < 18) ? $urandom_range(1, 8) : ((r == 18) ? TO : TO + 1));
            issue(sel, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  $urandom, 3'($urandom), 2'($urandom), $urandom, dly);
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(2);
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        // Reset while a load is pending: the late response must be dropped.
        in_valid_i = 1'b1; in_wb_sel_i = WB_MEM; in_reg_write_i = 1'b1; in_rd_i = 5'd12;
        in_funct3_i = F3_LW; in_addr_lo_i = 2'd0; dmem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("rst_wait_ready", 64'(in_ready_o), 64'd1);
        chk("rst_wait_we", 64'(WB_RegWrite_o), 64'd0);
        chk("rst_wait_err", 64'(err_o), 64'd0);
        chk("rst_wait_instret", instret_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        chk("late_rsp_no_retire", 64'(retire_o), 64'd0);
        chk("late_rsp_no_write", 64'(WB_RegWrite_o), 64'd0);
        chk("late_rsp_ready", 64'(in_ready_o), 64'd1);
        chk("late_rsp_instret", instret_o, 64'd0);
        issue(WB_ALU, 1'b1, 5'd6, 32'h0BAD_CAFE, $urandom, 3'd0, 2'd0, 32'd0, 0);
        idle_cycles(2);
        chk("final_queue_drained", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
